// File: rtl/bidir_bus_sched.sv
// bidir_bus_sched
// Half-duplex scheduler for the shared bidirectional card data bus. It arbitrates
// between a write requester, which drives bursts onto the bus, and a read requester,
// which samples bursts off it. Every burst is preceded by TURN_CYC turnaround cycles
// and followed by a single DONE cycle, so there is at least one IDLE cycle between bursts.
//
// Ports:
//   CLK, RST_N         rising-edge clock, asynchronous active-low reset
//   WR_REQ/WR_LEN      level write request and beats-minus-one (sampled at grant)
//   WR_DATA/WR_ACK     next write word; WR_ACK means it is consumed at the end of this cycle
//   RD_REQ/RD_LEN      level read request and beats-minus-one (sampled at grant)
//   RD_DATA/RD_VALID   registered bus sample and its valid strobe
//   READ_WRITE         1 = bus released (input), 0 = this block drives DATA
//   DATA               shared tri-state data pads
//   BUSY               high in every state except IDLE
//   DONE               one-cycle pulse in the cycle that closes a burst
module bidir_bus_sched #(
    parameter int DW       = 2,
    parameter int LENW     = 4,
    parameter int TURN_CYC = 2
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            WR_REQ,
    input  logic [LENW-1:0] WR_LEN,
    input  logic [DW-1:0]   WR_DATA,
    output logic            WR_ACK,
    input  logic            RD_REQ,
    input  logic [LENW-1:0] RD_LEN,
    output logic [DW-1:0]   RD_DATA,
    output logic            RD_VALID,
    output logic            READ_WRITE,
    inout  wire  [DW-1:0]   DATA,
    output logic            BUSY,
    output logic            DONE
);

    localparam int TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TURN,
        S_XFER_WR,
        S_XFER_RD,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     turn_cnt_q, turn_cnt_d;
    logic [LENW-1:0]   beat_cnt_q, beat_cnt_d;
    logic              dir_wr_q, dir_wr_d;
    logic              last_wr_q, last_wr_d;
    logic [DW-1:0]     out_q, out_d;
    logic [DW-1:0]     rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              grant_wr;
    logic              wr_ack;

    // State and datapath registers. Because READ_WRITE is decoded from the state,
    // the asynchronous reset releases the bus immediately without waiting for CLK.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            turn_cnt_q <= '0;
            beat_cnt_q <= '0;
            dir_wr_q   <= 1'b0;
            last_wr_q  <= 1'b0;
            out_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            turn_cnt_q <= turn_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            dir_wr_q   <= dir_wr_d;
            last_wr_q  <= last_wr_d;
            out_q      <= out_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Next-state logic, arbitration and beat counting.
    always_comb begin
        state_d    = state_q;
        turn_cnt_d = turn_cnt_q;
        beat_cnt_d = beat_cnt_q;
        dir_wr_d   = dir_wr_q;
        last_wr_d  = last_wr_q;
        // On a tie the grant goes to the type that did not win last time.
        grant_wr   = WR_REQ && (!RD_REQ || !last_wr_q);

        case (state_q)
            S_IDLE: begin
                if (WR_REQ || RD_REQ) begin
                    state_d    = S_TURN;
                    dir_wr_d   = grant_wr;
                    last_wr_d  = grant_wr;
                    beat_cnt_d = grant_wr ? WR_LEN : RD_LEN;
                    turn_cnt_d = TW'(TURN_CYC - 1);
                end
            end
            S_TURN: begin
                if (turn_cnt_q == '0) begin
                    state_d = dir_wr_q ? S_XFER_WR : S_XFER_RD;
                end else begin
                    turn_cnt_d = turn_cnt_q - TW'(1);
                end
            end
            S_XFER_WR, S_XFER_RD: begin
                if (beat_cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    beat_cnt_d = beat_cnt_q - LENW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Write words are fetched one cycle ahead of being driven: the first ACK falls in the
    // last TURN cycle so out_q holds word i during XFER_WR beat i, and the final XFER_WR
    // cycle needs no fetch. Reads register the pads on every XFER_RD edge, so RD_VALID
    // trails the bus by one cycle and overlaps DONE.
    always_comb begin
        wr_ack     = ((state_q == S_TURN) && (turn_cnt_q == '0) && dir_wr_q) ||
                     ((state_q == S_XFER_WR) && (beat_cnt_q != '0));
        out_d      = wr_ack ? WR_DATA : out_q;
        rd_valid_d = (state_q == S_XFER_RD);
        rd_data_d  = (state_q == S_XFER_RD) ? DATA : rd_data_q;
    end

    assign WR_ACK     = wr_ack;
    assign RD_DATA    = rd_data_q;
    assign RD_VALID   = rd_valid_q;
    assign READ_WRITE = (state_q != S_XFER_WR);
    assign BUSY       = (state_q != S_IDLE);
    assign DONE       = (state_q == S_DONE);
    assign DATA       = READ_WRITE ? {DW{1'bz}} : out_q;

endmodule

// File: tb/tb_bidir_bus_sched.sv
module tb_bidir_bus_sched;

    localparam int DW   = 2;
    localparam int LENW = 4;
    localparam int TURN = 2;

    typedef struct packed {
        logic             isWr;
        logic [3:0]       len;
        logic [15:0][1:0] words;
    } burstT;

    logic       clk = 1'b0;
    logic       rstN;
    logic       wrReq;
    logic       rdReq;
    logic [3:0] wrLen;
    logic [3:0] rdLen;
    logic [1:0] wrData = '0;
    logic       wrAck;
    logic [1:0] rdData;
    logic       rdValid;
    logic       readWrite;
    logic       busy;
    logic       done;
    wire  [1:0] dataBus;
    logic [1:0] tbDrive = '0;
    logic       tbDriveEn = 1'b0;

    burstT      burstQ[$];
    logic [1:0] rdQ[$];
    int         vectors = 0;
    int         errors = 0;
    bit         lastGrantWr = 1'b0;

    burstT      cur;
    bit         active = 1'b0;
    bit         busyPrev = 1'b0;
    bit         donePrev = 1'b0;
    int         idx = 0;
    int         ackIdx = 0;
    int         xs;
    int         xe;
    logic       expRw;
    logic       expAck;
    logic       expDone;
    logic       expRv;

    assign dataBus = tbDriveEn ? tbDrive : 2'bzz;

    always #5 clk = ~clk;

    bidir_bus_sched #(.DW(DW), .LENW(LENW), .TURN_CYC(TURN)) dut (
        .CLK        (clk),
        .RST_N      (rstN),
        .WR_REQ     (wrReq),
        .WR_LEN     (wrLen),
        .WR_DATA    (wrData),
        .WR_ACK     (wrAck),
        .RD_REQ     (rdReq),
        .RD_LEN     (rdLen),
        .RD_DATA    (rdData),
        .RD_VALID   (rdValid),
        .READ_WRITE (readWrite),
        .DATA       (dataBus),
        .BUSY       (busy),
        .DONE       (done)
    );

    // Single comparison point: counts every vector and reports any miscompare.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Record an expected burst and update the bench's own view of the last grant.
    task automatic expectBurst(input bit isWr, input logic [3:0] len, input logic [15:0][1:0] words);
        burstT b;
        b.isWr  = isWr;
        b.len   = len;
        b.words = words;
        burstQ.push_back(b);
        lastGrantWr = isWr;
    endtask

    // Raise one request and push the burst it must produce.
    task automatic applyStimulus(input bit isWr, input logic [3:0] len, input logic [15:0][1:0] words);
        expectBurst(isWr, len, words);
        if (isWr) begin
            wrLen = len;
            wrReq = 1'b1;
        end else begin
            rdLen = len;
            rdReq = 1'b1;
        end
    endtask

    task automatic waitBusy(input int maxCycles);
        int n = 0;
        while (!busy && n < maxCycles) begin
            @(negedge clk); #1;
            n++;
        end
        if (!busy) checkOutput("busy_timeout", busy, 1);
    endtask

    task automatic waitIdle(input int maxCycles);
        int n = 0;
        while ((busy || burstQ.size() != 0 || rdQ.size() != 0) && n < maxCycles) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput("idle_busy", busy, 0);
        checkOutput("queue_drained", 32'(burstQ.size() + rdQ.size()), 0);
    endtask

    // Monitor, reference timing model and bus-side driver, all sampled mid-cycle.
    always @(negedge clk) begin
        if (!rstN) begin
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_rw", readWrite, 1);
            checkOutput("rst_ack", wrAck, 0);
            checkOutput("rst_done", done, 0);
            checkOutput("rst_rv", rdValid, 0);
            active    = 1'b0;
            busyPrev  = 1'b0;
            donePrev  = 1'b0;
            ackIdx    = 0;
            tbDriveEn = 1'b0;
            burstQ.delete();
            rdQ.delete();
        end else begin
            if (donePrev) checkOutput("busy_after_done", busy, 0);
            if (busy && !busyPrev) begin
                checkOutput("grant_expected", 32'(burstQ.size() != 0), 1);
                if (burstQ.size() != 0) begin
                    cur    = burstQ.pop_front();
                    active = 1'b1;
                    idx    = 0;
                    ackIdx = 0;
                end
            end else if (busy) begin
                idx++;
            end
            if (!busy && busyPrev && active) begin
                checkOutput("busy_len", idx + 1, TURN + int'(cur.len) + 2);
                active = 1'b0;
            end

            xs      = TURN;
            xe      = TURN + int'(cur.len);
            expRw   = !(active && busy && cur.isWr && idx >= xs && idx <= xe);
            expAck  = active && busy && cur.isWr && idx >= TURN - 1 && idx < xe;
            expDone = active && busy && idx == xe + 1;
            expRv   = active && busy && !cur.isWr && idx >= xs + 1 && idx <= xe + 1;
            checkOutput("read_write", readWrite, expRw);
            checkOutput("wr_ack", wrAck, expAck);
            checkOutput("done", done, expDone);
            checkOutput("rd_valid", rdValid, expRv);

            if (!readWrite && active && cur.isWr && idx >= xs && idx <= xe)
                checkOutput("wr_bus_word", dataBus, cur.words[idx - xs]);
            if (rdValid && rdQ.size() != 0)
                checkOutput("rd_data", rdData, rdQ.pop_front());

            // Present the word that this ACK cycle consumes.
            if (wrAck && active && cur.isWr && ackIdx < 16) begin
                wrData = cur.words[ackIdx];
                ackIdx++;
            end

            // Far end drives the bus only during the read transfer cycles.
            if (active && busy && !cur.isWr && idx >= xs && idx <= xe) begin
                tbDrive   = cur.words[idx - xs];
                tbDriveEn = 1'b1;
                rdQ.push_back(cur.words[idx - xs]);
            end else begin
                tbDriveEn = 1'b0;
            end

            busyPrev = busy;
            donePrev = done;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0][1:0] w;
        int doneCnt;
        int n;

        // Reset held with a write request present: nothing may start.
        rstN  = 1'b0;
        wrReq = 1'b1;
        rdReq = 1'b0;
        wrLen = '0;
        rdLen = '0;
        repeat (3) @(negedge clk);
        #1;
        wrReq = 1'b0;
        rstN  = 1'b1;
        lastGrantWr = 1'b0;
        repeat (2) @(negedge clk);
        #1;

        $display("[TB] write burst LEN=3");
        w = '0;
        w[0] = 2'b01; w[1] = 2'b10; w[2] = 2'b11; w[3] = 2'b00;
        applyStimulus(1'b1, 4'd3, w);
        waitBusy(10);
        wrReq = 1'b0;
        waitIdle(40);

        $display("[TB] read burst LEN=1");
        w = '0;
        w[0] = 2'b11; w[1] = 2'b10;
        applyStimulus(1'b0, 4'd1, w);
        waitBusy(10);
        rdReq = 1'b0;
        waitIdle(40);

        $display("[TB] write burst LEN=0");
        w = '0;
        w[0] = 2'b10;
        applyStimulus(1'b1, 4'd0, w);
        waitBusy(10);
        wrReq = 1'b0;
        waitIdle(40);

        $display("[TB] read burst LEN=5, request dropped mid-transfer");
        w = '0;
        w[0] = 2'b01; w[1] = 2'b10; w[2] = 2'b11; w[3] = 2'b00; w[4] = 2'b10; w[5] = 2'b01;
        applyStimulus(1'b0, 4'd5, w);
        waitBusy(10);
        n = 0;
        while (!rdValid && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput("rd_valid_seen", rdValid, 1);
        rdReq = 1'b0;
        waitIdle(40);
        repeat (4) @(negedge clk);
        #1;

        $display("[TB] reset during write transfer");
        w = '0;
        for (int i = 0; i < 8; i++) w[i] = 2'(i);
        applyStimulus(1'b1, 4'd7, w);
        waitBusy(10);
        n = 0;
        while (readWrite && n < 20) begin
            @(posedge clk); #3;
            n++;
        end
        checkOutput("reached_xfer_wr", readWrite, 0);
        rstN = 1'b0;
        #1;
        checkOutput("async_rw", readWrite, 1);
        checkOutput("async_busy", busy, 0);
        checkOutput("async_ack", wrAck, 0);
        checkOutput("async_done", done, 0);
        wrReq = 1'b0;
        lastGrantWr = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rstN = 1'b1;
        repeat (2) @(negedge clk);
        #1;

        $display("[TB] tie with both requests held, LEN=0");
        w = '0;
        w[0] = 2'b11;
        for (int i = 0; i < 4; i++) begin
            if (!lastGrantWr) begin
                w[0] = 2'b11;
                expectBurst(1'b1, 4'd0, w);
            end else begin
                w[0] = 2'b01;
                expectBurst(1'b0, 4'd0, w);
            end
        end
        wrLen = '0;
        rdLen = '0;
        wrReq = 1'b1;
        rdReq = 1'b1;
        doneCnt = 0;
        n = 0;
        while (doneCnt < 4 && n < 60) begin
            @(negedge clk); #1;
            if (done) doneCnt++;
            n++;
        end
        wrReq = 1'b0;
        rdReq = 1'b0;
        checkOutput("tie_done_count", doneCnt, 4);
        waitIdle(40);
        repeat (4) @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
